// File: rtl/mode1_max_reduce_pkg.sv
// Shared FP16 layout constants and the non-IEEE ordering helpers used by every
// comparator of the max-reduction front end.
package mode1_max_reduce_pkg;

    localparam int DATAWIDTH = 16;
    localparam int MANTISSA  = 10;
    localparam int EXPONENT  = 5;
    localparam int LANES     = 8;

    // Signed ordering key: zero exponent flushes to 0 (so +0, -0 and subnormals tie),
    // Inf/NaN encodings keep their raw magnitude and order as ordinary values.
    function automatic logic signed [DATAWIDTH:0] fp_key(input logic [DATAWIDTH-1:0] x);
        logic signed [DATAWIDTH:0] mag;
        mag = $signed({2'b00, x[DATAWIDTH-2:0]});
        if (x[MANTISSA +: EXPONENT] == '0) begin
            return '0;
        end
        return x[DATAWIDTH-1] ? -mag : mag;
    endfunction

    // The left operand survives unless the right one is strictly greater.
    function automatic logic [DATAWIDTH-1:0] fp_max(input logic [DATAWIDTH-1:0] left,
                                                    input logic [DATAWIDTH-1:0] right);
        return (fp_key(right) > fp_key(left)) ? right : left;
    endfunction

endpackage

// File: rtl/mode1_max_reduce_max_tree_8.sv
// Combinational 3-level compare tree, 8 lanes -> 1. Left inputs are always the
// lower-lane group, so the lowest lane holding the maximum wins.
module mode1_max_reduce_max_tree_8
    import mode1_max_reduce_pkg::*;
(
    input  logic [LANES*DATAWIDTH-1:0] i_lanes,
    output logic [DATAWIDTH-1:0]       o_max
);

    logic [DATAWIDTH-1:0] w_l1 [4];
    logic [DATAWIDTH-1:0] w_l2 [2];

    for (genvar g = 0; g < 4; g++) begin : g_level1
        assign w_l1[g] = fp_max(i_lanes[(2*g)*DATAWIDTH   +: DATAWIDTH],
                                i_lanes[(2*g+1)*DATAWIDTH +: DATAWIDTH]);
    end

    assign w_l2[0] = fp_max(w_l1[0], w_l1[1]);
    assign w_l2[1] = fp_max(w_l1[2], w_l1[3]);
    assign o_max   = fp_max(w_l2[0], w_l2[1]);

endmodule

// File: rtl/mode1_max_reduce.sv
// Streaming max-reduction front end: registered 8->1 tree (S1) feeding a running
// accumulator (S2); one scalar result per vector with a valid/ready handshake.
module mode1_max_reduce
    import mode1_max_reduce_pkg::*;
#(
    parameter int BEAT_W = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 in_last,
    input  logic [DATAWIDTH-1:0] in_data0,
    input  logic [DATAWIDTH-1:0] in_data1,
    input  logic [DATAWIDTH-1:0] in_data2,
    input  logic [DATAWIDTH-1:0] in_data3,
    input  logic [DATAWIDTH-1:0] in_data4,
    input  logic [DATAWIDTH-1:0] in_data5,
    input  logic [DATAWIDTH-1:0] in_data6,
    input  logic [DATAWIDTH-1:0] in_data7,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DATAWIDTH-1:0] out_max,
    output logic [BEAT_W-1:0]    out_beats,
    output logic                 overflow
);

    localparam logic [BEAT_W-1:0] CNT_MAX = '1;

    logic [LANES*DATAWIDTH-1:0] w_lanes;
    logic [DATAWIDTH-1:0]       w_tree_max;
    logic [DATAWIDTH-1:0]       w_acc_next;
    logic                       w_accept;

    logic                 r_busy;
    logic                 r_first_in;
    logic [BEAT_W-1:0]    r_beat_cnt;
    logic                 r_overflow;
    logic                 r_s1_valid;
    logic [DATAWIDTH-1:0] r_s1_max;
    logic                 r_s1_first;
    logic                 r_s1_last;
    logic [DATAWIDTH-1:0] r_acc;
    logic                 r_out_valid;
    logic [DATAWIDTH-1:0] r_out_max;
    logic [BEAT_W-1:0]    r_out_beats;

    assign w_lanes  = {in_data7, in_data6, in_data5, in_data4,
                       in_data3, in_data2, in_data1, in_data0};
    assign w_accept = in_valid & ~r_busy;

    mode1_max_reduce_max_tree_8 u_tree (
        .i_lanes (w_lanes),
        .o_max   (w_tree_max)
    );

    // Accumulator is the left operand, so an equal later beat never replaces it.
    assign w_acc_next = r_s1_first ? r_s1_max : fp_max(r_acc, r_s1_max);

    // NOTE: S1 payload is only ever consumed under r_s1_valid, so it carries no reset
    // and loads only on an accepted beat (idle lanes are never sampled).
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_s1_max   <= w_tree_max;
            r_s1_first <= r_first_in;
            r_s1_last  <= in_last;
        end
    end

    // NOTE: all state updates are non-blocking so every term reads pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_busy      <= 1'b0;
            r_first_in  <= 1'b1;
            r_beat_cnt  <= '0;
            r_overflow  <= 1'b0;
            r_s1_valid  <= 1'b0;
            r_acc       <= '0;
            r_out_valid <= 1'b0;
            r_out_max   <= '0;
            r_out_beats <= '0;
        end else begin
            r_s1_valid <= w_accept;

            if (w_accept) begin
                r_first_in <= in_last;
                if (in_last) begin
                    r_busy <= 1'b1;
                end
                if (r_first_in) begin
                    r_beat_cnt <= BEAT_W'(1);
                end else if (r_beat_cnt == CNT_MAX) begin
                    r_overflow <= 1'b1;
                end else begin
                    r_beat_cnt <= r_beat_cnt + 1'b1;
                end
            end

            if (r_s1_valid) begin
                r_acc <= w_acc_next;
                if (r_s1_last) begin
                    r_out_valid <= 1'b1;
                    r_out_max   <= w_acc_next;
                    r_out_beats <= r_beat_cnt;
                end
            end

            // in_ready returns together with out_valid falling.
            if (r_out_valid && out_ready) begin
                r_out_valid <= 1'b0;
                r_busy      <= 1'b0;
            end
        end
    end

    assign in_ready  = ~r_busy;
    assign out_valid = r_out_valid;
    assign out_max   = r_out_max;
    assign out_beats = r_out_beats;
    assign overflow  = r_overflow;

endmodule

// File: tb/tb_mode1_max_reduce.sv
// Bench for mode1_max_reduce: two instances (BEAT_W=8 and BEAT_W=2) share one stimulus
// stream and are checked each cycle against a real-valued reference model.
module tb_mode1_max_reduce;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_last = 1'b0;
    logic [15:0] in_d [8];
    logic        out_ready = 1'b1;

    logic        in_ready_a, out_valid_a, overflow_a;
    logic [15:0] out_max_a;
    logic [7:0]  out_beats_a;
    logic        in_ready_b, out_valid_b, overflow_b;
    logic [15:0] out_max_b;
    logic [1:0]  out_beats_b;

    always #5 clk = ~clk;

    mode1_max_reduce #(.BEAT_W(8)) dut_a (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_a), .in_last(in_last),
        .in_data0(in_d[0]), .in_data1(in_d[1]), .in_data2(in_d[2]), .in_data3(in_d[3]),
        .in_data4(in_d[4]), .in_data5(in_d[5]), .in_data6(in_d[6]), .in_data7(in_d[7]),
        .out_valid(out_valid_a), .out_ready(out_ready), .out_max(out_max_a),
        .out_beats(out_beats_a), .overflow(overflow_a)
    );

    mode1_max_reduce #(.BEAT_W(2)) dut_b (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_b), .in_last(in_last),
        .in_data0(in_d[0]), .in_data1(in_d[1]), .in_data2(in_d[2]), .in_data3(in_d[3]),
        .in_data4(in_d[4]), .in_data5(in_d[5]), .in_data6(in_d[6]), .in_data7(in_d[7]),
        .out_valid(out_valid_b), .out_ready(out_ready), .out_max(out_max_b),
        .out_beats(out_beats_b), .overflow(overflow_b)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic real fp_val(input logic [15:0] x);
        int  e;
        real v;
        e = int'(x[14:10]);
        if (e == 0) return 0.0;
        v = (1.0 + real'(x[9:0]) / 1024.0) * (2.0 ** (e - 15));
        return x[15] ? -v : v;
    endfunction

    typedef struct {
        logic [15:0] mx;
        int          beats;
        int          vis;
    } res_t;

    res_t        m_q[$];
    bit          m_init = 0, m_busy = 0, m_run_any = 0, m_ovf_a = 0, m_ovf_b = 0;
    bit          m_exp_ov, m_acc;
    int          m_run_cnt = 0, m_cyc = 0;
    logic [15:0] m_run_max = '0;

    always @(negedge clk) begin
        m_cyc++;
        m_exp_ov = (m_q.size() > 0) && (m_q[0].vis <= m_cyc);
        if (m_init) begin
            check("in_ready_a", 32'(in_ready_a), 32'(!m_busy));
            check("in_ready_b", 32'(in_ready_b), 32'(!m_busy));
            check("out_valid_a", 32'(out_valid_a), 32'(m_exp_ov));
            check("out_valid_b", 32'(out_valid_b), 32'(m_exp_ov));
            check("overflow_a", 32'(overflow_a), 32'(m_ovf_a));
            check("overflow_b", 32'(overflow_b), 32'(m_ovf_b));
            if (m_exp_ov) begin
                check("out_max_a", 32'(out_max_a), 32'(m_q[0].mx));
                check("out_max_b", 32'(out_max_b), 32'(m_q[0].mx));
                check("out_beats_a", 32'(out_beats_a), 32'((m_q[0].beats > 255) ? 255 : m_q[0].beats));
                check("out_beats_b", 32'(out_beats_b), 32'((m_q[0].beats > 3) ? 3 : m_q[0].beats));
            end
        end
        if (reset) begin
            m_init = 1; m_busy = 0; m_run_any = 0; m_run_cnt = 0;
            m_ovf_a = 0; m_ovf_b = 0; m_q.delete();
        end else if (m_init) begin
            m_acc = in_valid && !m_busy;
            if (m_exp_ov && out_ready) begin
                void'(m_q.pop_front());
                m_busy = 0;
            end
            if (m_acc) begin
                // Running max over the flattened element stream; first occurrence wins ties.
                for (int i = 0; i < 8; i++) begin
                    if (!m_run_any || fp_val(in_d[i]) > fp_val(m_run_max)) m_run_max = in_d[i];
                    m_run_any = 1;
                end
                m_run_cnt++;
                if (m_run_cnt > 255) m_ovf_a = 1;
                if (m_run_cnt > 3)   m_ovf_b = 1;
                if (in_last) begin
                    m_q.push_back('{mx: m_run_max, beats: m_run_cnt, vis: m_cyc + 2});
                    m_busy = 1; m_run_any = 0; m_run_cnt = 0;
                end
            end
        end
    end

    // ---------------- out_ready driver ----------------
    bit ordy_mode = 0;
    bit ordy_force = 1;
    always @(posedge clk) begin
        #1;
        out_ready = ordy_mode ? 1'($urandom_range(0, 1)) : ordy_force;
    end

    // ---------------- stimulus helpers ----------------
    function automatic logic [127:0] pk(input logic [15:0] a0, a1, a2, a3, a4, a5, a6, a7);
        return {a7, a6, a5, a4, a3, a2, a1, a0};
    endfunction

    function automatic logic [127:0] splat(input logic [15:0] v);
        return {8{v}};
    endfunction

    function automatic logic [15:0] rand_lane();
        case ($urandom_range(0, 9))
            0: return 16'h0000;
            1: return 16'h8000;
            2: return 16'h7BFF;
            3: return 16'hFBFF;
            4: return 16'h7C00;
            5: return 16'hFC00;
            default: return 16'($urandom);
        endcase
    endfunction

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic drive_beat(input logic [127:0] lanes, input bit last);
        bit ok = 0;
        int n = 0;
        for (int i = 0; i < 8; i++) in_d[i] = lanes[16*i +: 16];
        in_valid = 1'b1;
        in_last  = last;
        while (!ok && n < 50) begin
            @(negedge clk);
            ok = (in_ready_a === 1'b1);
            @(posedge clk); #1;
            n++;
        end
        if (!ok) check("accept_bound", 32'(ok), 32'd1);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_result(input string tag, input logic [15:0] emax, input int eba, input int ebb);
        int n = 0;
        do begin @(negedge clk); n++; end while (out_valid_a !== 1'b1 && n < 20);
        check({tag, "_valid"}, 32'(out_valid_a), 32'd1);
        check({tag, "_max_a"}, 32'(out_max_a), 32'(emax));
        check({tag, "_max_b"}, 32'(out_max_b), 32'(emax));
        check({tag, "_beats_a"}, 32'(out_beats_a), 32'(eba));
        check({tag, "_beats_b"}, 32'(out_beats_b), 32'(ebb));
        @(posedge clk); #1;
    endtask

    task automatic check_reset_state(input string tag);
        @(negedge clk);
        check({tag, "_in_ready"}, 32'(in_ready_a), 32'd1);
        check({tag, "_out_valid"}, 32'(out_valid_a), 32'd0);
        check({tag, "_out_max"}, 32'(out_max_a), 32'd0);
        check({tag, "_out_beats"}, 32'(out_beats_a), 32'd0);
        check({tag, "_overflow_a"}, 32'(overflow_a), 32'd0);
        check({tag, "_overflow_b"}, 32'(overflow_b), 32'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 8; i++) in_d[i] = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        check_reset_state("reset");

        // 1: single beat, latency and in_ready window
        drive_beat(pk(16'hBC00, 16'h3C00, 16'h0000, 16'h4000, 16'hBC00, 16'h0000, 16'h3C00, 16'hFBFF), 1);
        @(negedge clk);
        check("t1_ready_t1", 32'(in_ready_a), 32'd0);
        check("t1_valid_t1", 32'(out_valid_a), 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        check("t1_ready_t2", 32'(in_ready_a), 32'd0);
        check("t1_valid_t2", 32'(out_valid_a), 32'd1);
        check("t1_max", 32'(out_max_a), 32'h4000);
        check("t1_beats", 32'(out_beats_a), 32'd1);
        @(posedge clk); #1;
        @(negedge clk);
        check("t1_ready_t3", 32'(in_ready_a), 32'd1);
        check("t1_valid_t3", 32'(out_valid_a), 32'd0);
        @(posedge clk); #1;

        // 2: three beats back to back
        drive_beat(pk(16'hBC00, 16'h3C00, 16'h0000, 16'h3800, 16'hBC00, 16'h0000, 16'h3C00, 16'hFBFF), 0);
        drive_beat(pk(16'h0000, 16'h4000, 16'h7BFF, 16'h3C00, 16'hFBFF, 16'h8000, 16'h4400, 16'h0000), 0);
        drive_beat(pk(16'h3C00, 16'h3C00, 16'h4000, 16'hBC00, 16'hBC00, 16'h3800, 16'h0000, 16'h8000), 1);
        wait_result("t2", 16'h7BFF, 3, 3);

        // 3: consumer stall, then next vector right after the handshake
        ordy_force = 0;
        idle(2);
        drive_beat(pk(16'h3C00, 16'h4400, 16'h0000, 16'h4000, 16'hBC00, 16'h0000, 16'h3C00, 16'hFBFF), 1);
        wait_result("t3", 16'h4400, 1, 1);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("t3_hold_valid", 32'(out_valid_a), 32'd1);
            check("t3_hold_max", 32'(out_max_a), 32'h4400);
            check("t3_hold_ready", 32'(in_ready_a), 32'd0);
            @(posedge clk); #1;
        end
        ordy_force = 1;
        drive_beat(splat(16'hBC00), 1);
        wait_result("t3_next", 16'hBC00, 1, 1);

        // 4: signed-zero ties keep the lower lane
        drive_beat(pk(16'hBC00, 16'hBC00, 16'h0000, 16'hBC00, 16'hBC00, 16'h8000, 16'hBC00, 16'hBC00), 1);
        wait_result("t4_pos", 16'h0000, 1, 1);
        drive_beat(pk(16'hBC00, 16'h8000, 16'hBC00, 16'hBC00, 16'h0000, 16'hBC00, 16'hBC00, 16'hBC00), 1);
        wait_result("t4_neg", 16'h8000, 1, 1);

        // 5: reset in the middle of a vector
        drive_beat(splat(16'h7BFF), 0);
        drive_beat(splat(16'h7800), 0);
        reset = 1'b1;
        idle(1);
        reset = 1'b0;
        check_reset_state("t5_reset");
        drive_beat(splat(16'h3C00), 1);
        wait_result("t5", 16'h3C00, 1, 1);

        // 6: beat counter saturation on the BEAT_W=2 instance
        drive_beat(splat(16'h3C00), 0);
        drive_beat(splat(16'h4000), 0);
        drive_beat(pk(16'h0000, 16'h4400, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000), 0);
        drive_beat(splat(16'h3800), 1);
        wait_result("t6", 16'h4400, 4, 3);
        check("t6_ovf_b", 32'(overflow_b), 32'd1);
        check("t6_ovf_a", 32'(overflow_a), 32'd0);
        drive_beat(splat(16'h3800), 1);
        wait_result("t6_next", 16'h3800, 1, 1);
        check("t6_ovf_sticky", 32'(overflow_b), 32'd1);
        reset = 1'b1;
        idle(1);
        reset = 1'b0;
        check_reset_state("t6_reset");

        // Randomized traffic with random backpressure
        ordy_mode = 1;
        for (int v = 0; v < 400; v++) begin
            int len;
            len = $urandom_range(1, 6);
            if (v == 150) begin
                drive_beat(splat(rand_lane()), 0);
                drive_beat(splat(rand_lane()), 0);
                reset = 1'b1;
                idle(1);
                reset = 1'b0;
            end
            for (int b = 0; b < len; b++) begin
                drive_beat(pk(rand_lane(), rand_lane(), rand_lane(), rand_lane(),
                              rand_lane(), rand_lane(), rand_lane(), rand_lane()), b == len - 1);
                if ($urandom_range(0, 3) == 0) idle(1);
            end
            if (v == 300) begin
                ordy_mode = 0;
                ordy_force = 0;
                idle(3);
                reset = 1'b1;
                idle(1);
                reset = 1'b0;
                ordy_mode = 1;
            end
        end
        ordy_mode = 0;
        ordy_force = 1;
        idle(10);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
